hazard_ctrl_unit: RTL and testbench

//  Pipeline hazard controller for the 5-stage core. Keeps internal shadow copies of the E/M/W

---
 rtl/hazard_ctrl_unit.sv | 157 +++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: stall, flush and forward selects for the 5-stage core.
// Define HAZARD_STATS_EN to add saturating StallCount/FlushCount outputs.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int PCSRC_W    = 2
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W     = 32
`endif
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  RegDstD,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic [PCSRC_W-1:0]    PCSrcD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     StallCount,
  output logic [STAT_W-1:0]     FlushCount
`endif
);

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  // Each stage keeps only the fields later hazard checks still look at.
  typedef struct packed {
    logic     reg_write;
    reg_idx_t write_reg;
  } wb_info_t;

  typedef struct packed {
    logic     mem_to_reg;
    wb_info_t wb;
  } mem_info_t;

  typedef struct packed {
    reg_idx_t  rs;
    reg_idx_t  rt;
    mem_info_t mem;
  } ex_info_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  ex_info_t  dec_info;
  ex_info_t  ex_q;
  mem_info_t mem_q;
  wb_info_t  wb_q;

  logic lw_stall;
  logic br_stall;
  logic stall;
  logic redirect;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic reg_match(input reg_idx_t a, input reg_idx_t b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input reg_idx_t src,
                                         input mem_info_t m,
                                         input wb_info_t w);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (m.wb.reg_write && reg_match(src, m.wb.write_reg)) begin
      sel = FWD_MEM;
    end else if (w.reg_write && reg_match(src, w.write_reg)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    // NOTE: every field gets a value on every path, so no latch is inferred.
    dec_info                  = '0;
    dec_info.rs               = RsD;
    dec_info.rt               = RtD;
    dec_info.mem.mem_to_reg   = MemtoRegD;
    dec_info.mem.wb.reg_write = RegWriteD;
    dec_info.mem.wb.write_reg = RegDstD ? RdD : RtD;
  end

  assign lw_stall = ex_q.mem.mem_to_reg && ex_q.mem.wb.reg_write &&
                    (reg_match(RsD, ex_q.mem.wb.write_reg) ||
                     reg_match(RtD, ex_q.mem.wb.write_reg));

  // A branch compares in decode, so it must wait for any result not yet in M,
  // and for a load result still in M (the data arrives only at the end of M).
  assign br_stall = BranchD &&
                    ((ex_q.mem.wb.reg_write &&
                      (reg_match(RsD, ex_q.mem.wb.write_reg) ||
                       reg_match(RtD, ex_q.mem.wb.write_reg))) ||
                     (mem_q.mem_to_reg &&
                      (reg_match(RsD, mem_q.wb.write_reg) ||
                       reg_match(RtD, mem_q.wb.write_reg))));

  assign stall    = lw_stall || br_stall;
  assign redirect = (PCSrcD != '0) || JumpD;

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;
  // A stalled redirect is re-evaluated once its operands are ready.
  assign FlushD = redirect && !stall;

  assign ForwardAD = mem_q.wb.reg_write && reg_match(RsD, mem_q.wb.write_reg);
  assign ForwardBD = mem_q.wb.reg_write && reg_match(RtD, mem_q.wb.write_reg);

  assign ForwardAE = fwd_sel(ex_q.rs, mem_q, wb_q);
  assign ForwardBE = fwd_sel(ex_q.rt, mem_q, wb_q);

  // E always advances; a stall turns into a bubble rather than a hold.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let the whole shadow pipeline shift in one edge.
      ex_q  <= stall ? '0 : dec_info;
      mem_q <= ex_q.mem;
      wb_q  <= mem_q.wb;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallD && (StallCount != '1)) begin
        StallCount <= StallCount + STAT_W'(1);
      end
      if (FlushD && (FlushCount != '1)) begin
        FlushCount <= FlushCount + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed vector table, reset corner case,
// and random decode streams checked against an instruction-level pipeline model.
module tb_hazard_ctrl_unit;

  localparam int STAT_W = 4;

  logic       CLK;
  logic       RST;
  logic [4:0] RsD, RtD, RdD;
  logic       RegWriteD, MemtoRegD, RegDstD, BranchD, JumpD;
  logic [1:0] PCSrcD;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] StallCount, FlushCount;
`endif

  hazard_ctrl_unit #(
    .REG_ADDR_W(5),
    .PCSRC_W   (2)
`ifdef HAZARD_STATS_EN
    ,
    .STAT_W    (STAT_W)
`endif
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RsD       (RsD),
    .RtD       (RtD),
    .RdD       (RdD),
    .RegWriteD (RegWriteD),
    .MemtoRegD (MemtoRegD),
    .RegDstD   (RegDstD),
    .BranchD   (BranchD),
    .JumpD     (JumpD),
    .PCSrcD    (PCSrcD),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAD (ForwardAD),
    .ForwardBD (ForwardBD),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount(StallCount),
    .FlushCount(FlushCount)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic       rw, m2r, rdst, br, j;
    logic [1:0] pcsrc;
  } din_t;

  typedef struct {
    din_t       d;
    logic [9:0] exp;
  } vec_t;

  // One in-flight instruction as the model sees it.
  typedef struct {
    logic       wr;
    logic       ld;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
  } ins_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  ins_t pipe [3];          // 0 = E, 1 = M, 2 = W
  int   m_stall_cnt;
  int   m_flush_cnt;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic din_t nop();
    return '0;
  endfunction

  function automatic din_t alu(input int rd, input int rs, input int rt);
    din_t d = '0;
    d.rd = 5'(rd); d.rs = 5'(rs); d.rt = 5'(rt);
    d.rw = 1'b1; d.rdst = 1'b1;
    return d;
  endfunction

  function automatic din_t ld(input int rt, input int rs);
    din_t d = '0;
    d.rt = 5'(rt); d.rs = 5'(rs);
    d.rw = 1'b1; d.m2r = 1'b1;
    return d;
  endfunction

  function automatic din_t beq(input int rs, input int rt, input int pcsrc);
    din_t d = '0;
    d.rs = 5'(rs); d.rt = 5'(rt);
    d.br = 1'b1; d.pcsrc = 2'(pcsrc);
    return d;
  endfunction

  function automatic din_t jmp();
    din_t d = '0;
    d.j = 1'b1;
    return d;
  endfunction

  function automatic logic [9:0] o(input logic stall, input logic fd, input logic fad,
                                   input logic fbd, input logic [1:0] fae,
                                   input logic [1:0] fbe);
    return {stall, stall, fd, stall, fad, fbd, fae, fbe};
  endfunction

  function automatic logic [9:0] dut_out();
    return {StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE};
  endfunction

  function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] model_sel(input logic [4:0] src);
    if (pipe[1].wr && hit(src, pipe[1].dst)) return 2'b10;
    if (pipe[2].wr && hit(src, pipe[2].dst)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] model_out(input din_t d);
    logic lw, br, stall, fd;
    lw = pipe[0].ld && pipe[0].wr && (hit(d.rs, pipe[0].dst) || hit(d.rt, pipe[0].dst));
    br = d.br && ((pipe[0].wr && (hit(d.rs, pipe[0].dst) || hit(d.rt, pipe[0].dst))) ||
                  (pipe[1].ld && (hit(d.rs, pipe[1].dst) || hit(d.rt, pipe[1].dst))));
    stall = lw || br;
    fd = ((d.pcsrc != 0) || d.j) && !stall;
    return o(stall, fd,
             pipe[1].wr && hit(d.rs, pipe[1].dst),
             pipe[1].wr && hit(d.rt, pipe[1].dst),
             model_sel(pipe[0].rs), model_sel(pipe[0].rt));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{default: '0};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // Advance the model by one clock with decode input d.
  task automatic model_step(input din_t d);
    logic [9:0] mo;
    ins_t       nxt;
    mo = model_out(d);
    if (mo[9] && m_stall_cnt < (1 << STAT_W) - 1) m_stall_cnt++;
    if (mo[7] && m_flush_cnt < (1 << STAT_W) - 1) m_flush_cnt++;
    nxt = '{default: '0};
    if (!mo[9]) begin
      nxt.wr  = d.rw;
      nxt.ld  = d.m2r;
      nxt.dst = d.rdst ? d.rd : d.rt;
      nxt.rs  = d.rs;
      nxt.rt  = d.rt;
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
  endtask

  task automatic drive(input din_t d);
    RsD = d.rs; RtD = d.rt; RdD = d.rd;
    RegWriteD = d.rw; MemtoRegD = d.m2r; RegDstD = d.rdst;
    BranchD = d.br; JumpD = d.j; PCSrcD = d.pcsrc;
  endtask

  // Starts and ends at a falling edge; outputs are sampled mid-cycle.
  task automatic run_cycle(input din_t d, input logic [9:0] exp, input string name);
    drive(d);
    #1;
    check(name, {22'd0, dut_out()}, {22'd0, exp});
    @(posedge CLK);
    model_step(d);
    @(negedge CLK);
  endtask

  task automatic reset_all();
    RST = 1'b0;
    drive(nop());
    model_clear();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    drive(nop());
    model_clear();
    #1;
    check("reset_state", {22'd0, dut_out()}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // load-use
    tbl.push_back('{ld(2, 1),       o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{alu(3, 2, 4),   o(1, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{alu(3, 2, 4),   o(0, 0, 1, 0, 2'b00, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b01, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b00, 2'b00)});
    // branch after ALU op, taken redirect held off by the stall
    tbl.push_back('{alu(5, 8, 9),   o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{beq(5, 6, 1),   o(1, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{beq(5, 6, 1),   o(0, 1, 1, 0, 2'b00, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b01, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b00, 2'b00)});
    // branch after load: two stall cycles
    tbl.push_back('{ld(5, 8),       o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{beq(5, 6, 0),   o(1, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{beq(5, 6, 0),   o(1, 0, 1, 0, 2'b00, 2'b00)});
    tbl.push_back('{beq(5, 6, 0),   o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b00, 2'b00)});
    // M beats W; then W alone
    tbl.push_back('{alu(7, 1, 2),   o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{alu(7, 3, 4),   o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{alu(9, 7, 7),   o(0, 0, 1, 1, 2'b00, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b10, 2'b10)});
    tbl.push_back('{alu(7, 3, 4),   o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{alu(10, 7, 0),  o(0, 0, 1, 0, 2'b00, 2'b00)});
    tbl.push_back('{nop(),          o(0, 0, 0, 0, 2'b01, 2'b00)});
    // register 0 never stalls or forwards; redirects flush
    tbl.push_back('{alu(0, 0, 0),   o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{ld(0, 0),       o(0, 0, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{beq(0, 0, 1),   o(0, 1, 0, 0, 2'b00, 2'b00)});
    tbl.push_back('{jmp(),          o(0, 1, 0, 0, 2'b00, 2'b00)});

    foreach (tbl[i]) run_cycle(tbl[i].d, tbl[i].exp, $sformatf("vec%0d", i));

`ifdef HAZARD_STATS_EN
    check("stall_count_dir", 32'(StallCount), 32'(m_stall_cnt));
    check("flush_count_dir", 32'(FlushCount), 32'(m_flush_cnt));
`endif

    // Reset asserted in the middle of a load-use stall.
    begin
      din_t c;
      reset_all();
      run_cycle(ld(2, 1), o(0, 0, 0, 0, 2'b00, 2'b00), "rst_seq_lw");
      c = alu(3, 2, 4);
      c.pcsrc = 2'b01;
      drive(c);
      #1;
      check("rst_seq_stall", {22'd0, dut_out()}, {22'd0, o(1, 0, 0, 0, 2'b00, 2'b00)});
      RST = 1'b0;
      model_clear();
      #1;
      check("rst_async", {22'd0, dut_out()}, {22'd0, o(0, 1, 0, 0, 2'b00, 2'b00)});
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check("rst_cleared", {22'd0, dut_out()}, {22'd0, o(0, 1, 0, 0, 2'b00, 2'b00)});
      @(negedge CLK);
    end

    // Random decode streams over a small register set to provoke frequent hazards.
    reset_all();
    for (int n = 0; n < 1500; n++) begin
      din_t d;
      d.rs    = 5'($urandom_range(0, 7));
      d.rt    = 5'($urandom_range(0, 7));
      d.rd    = 5'($urandom_range(0, 7));
      d.rw    = 1'($urandom_range(0, 3) != 0);
      d.m2r   = 1'($urandom_range(0, 3) == 0);
      d.rdst  = 1'($urandom_range(0, 1));
      d.br    = 1'($urandom_range(0, 3) == 0);
      d.j     = 1'($urandom_range(0, 7) == 0);
      d.pcsrc = 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
      run_cycle(d, model_out(d), $sformatf("rand%0d", n));
`ifdef HAZARD_STATS_EN
      if (n == 10) begin
        check("stall_count_early", 32'(StallCount), 32'(m_stall_cnt));
        check("flush_count_early", 32'(FlushCount), 32'(m_flush_cnt));
      end
`endif
    end

`ifdef HAZARD_STATS_EN
    check("stall_count_sat", 32'(StallCount), 32'(m_stall_cnt));
    check("flush_count_sat", 32'(FlushCount), 32'(m_flush_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
